// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with set-2 E0/F0 prefix decode and modifier tracking.
// Optional parity checking when PS2_RX_PARITY_CHECK_EN is defined.
//
// Ports:
//   clk_sys, reset                system clock, synchronous active-high reset
//   ps2_clk, ps2_data             PS/2 link inputs (asynchronous; clock idles high)
//   rx_data/rx_valid/rx_err       raw byte, 1-cycle valid pulse, 1-cycle error pulse
//   key_code/key_ext/key_released decoded key event, qualified by key_strobe
//   key_mods                      {alt, ctrl, rshift, lshift} currently held
module ps2_kbd_rx #(
    parameter int FILT    = 4,
    parameter int TIMEOUT = 2000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_released,
    output logic       key_strobe,
    output logic [3:0] key_mods
);

    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [FW-1:0] FCNT_MAX = FW'(FILT - 1);
    localparam logic [10:0]   TMO_LIM  = 11'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          flt_q, flt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [10:0]   tmr_q, tmr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif
    logic [7:0]    rxd_q, rxd_d;
    logic          rxv_q, rxv_d;
    logic          rxe_q, rxe_d;
    logic          extp_q, extp_d;
    logic          relp_q, relp_d;
    logic [7:0]    kc_q, kc_d;
    logic          kext_q, kext_d;
    logic          krel_q, krel_d;
    logic          kstb_q, kstb_d;
    logic [3:0]    mods_q, mods_d;

    logic sclk, sdat, fall, tout, acc, ferr;

    assign sclk = clk_s_q[1];
    assign sdat = dat_s_q[1];

    // The filtered level flips only after FILT consecutive differing samples;
    // the falling edge is that flip from 1 to 0.
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = '0;
        if (sclk != flt_q) begin
            if (fcnt_q == FCNT_MAX) flt_d = sclk;
            else                    fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign fall = flt_q & ~sclk & (fcnt_q == FCNT_MAX);
    assign tout = (state_q != S_IDLE) && (tmr_q == TMO_LIM);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        tmr_d   = tmr_q;
`ifdef PS2_RX_PARITY_CHECK_EN
        par_d   = par_q;
`endif
        acc     = 1'b0;
        ferr    = 1'b0;
        if (state_q == S_IDLE) tmr_d = '0;
        else if (fall)         tmr_d = '0;
        else                   tmr_d = tmr_q + 11'd1;
        // Timeout takes priority over a coincident edge.
        if (tout) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            ferr    = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!sdat) begin
                        state_d = S_DATA;
                        bcnt_d  = '0;
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_d   = 1'b0;
`endif
                    end
                end
                S_DATA: begin
                    shift_d = {sdat, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = S_PAR;
                end
                S_PAR: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                    par_d   = sdat;
`endif
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
`ifdef PS2_RX_PARITY_CHECK_EN
                    if (sdat && (^{shift_q, par_q})) acc  = 1'b1;
                    else                             ferr = 1'b1;
`else
                    if (sdat) acc  = 1'b1;
                    else      ferr = 1'b1;
`endif
                end
            endcase
        end
    end

    always_comb begin
        rxv_d = acc;
        rxe_d = ferr;
        rxd_d = acc ? shift_q : rxd_q;
    end

    // Prefix decode and modifier tracking, one cycle behind rx_valid.
    always_comb begin
        extp_d = extp_q;
        relp_d = relp_q;
        kc_d   = kc_q;
        kext_d = kext_q;
        krel_d = krel_q;
        kstb_d = 1'b0;
        mods_d = mods_q;
        if (rxe_q) begin
            extp_d = 1'b0;
            relp_d = 1'b0;
        end else if (rxv_q) begin
            case (rxd_q)
                8'hE0: extp_d = 1'b1;
                8'hF0: relp_d = 1'b1;
                default: begin
                    kc_d   = rxd_q;
                    kext_d = extp_q;
                    krel_d = relp_q;
                    kstb_d = 1'b1;
                    extp_d = 1'b0;
                    relp_d = 1'b0;
                    case (rxd_q)
                        8'h12:   mods_d[0] = ~relp_q;
                        8'h59:   mods_d[1] = ~relp_q;
                        8'h14:   mods_d[2] = ~relp_q;
                        8'h11:   mods_d[3] = ~relp_q;
                        default: mods_d    = mods_q;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            flt_q   <= 1'b1;
            fcnt_q  <= '0;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            tmr_q   <= '0;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
            rxe_q   <= 1'b0;
            extp_q  <= 1'b0;
            relp_q  <= 1'b0;
            kc_q    <= '0;
            kext_q  <= 1'b0;
            krel_q  <= 1'b0;
            kstb_q  <= 1'b0;
            mods_q  <= '0;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
            flt_q   <= flt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            tmr_q   <= tmr_d;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
            rxe_q   <= rxe_d;
            extp_q  <= extp_d;
            relp_q  <= relp_d;
            kc_q    <= kc_d;
            kext_q  <= kext_d;
            krel_q  <= krel_d;
            kstb_q  <= kstb_d;
            mods_q  <= mods_d;
        end
    end

    assign rx_data      = rxd_q;
    assign rx_valid     = rxv_q;
    assign rx_err       = rxe_q;
    assign key_code     = kc_q;
    assign key_ext      = kext_q;
    assign key_released = krel_q;
    assign key_strobe   = kstb_q;
    assign key_mods     = mods_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed PS/2 frames against a queue-based event model.
// Expected raw bytes, key events and error pulses are queued and popped on each DUT pulse.
module tb_ps2_kbd_rx;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_released;
    logic       key_strobe;
    logic [3:0] key_mods;

    always #5 clk_sys = ~clk_sys;

    ps2_kbd_rx #(.FILT(4), .TIMEOUT(2000)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .key_code(key_code), .key_ext(key_ext),
        .key_released(key_released), .key_strobe(key_strobe),
        .key_mods(key_mods)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [3:0] mods;
    } kev_t;

    int vec = 0;
    int mis = 0;
    logic [7:0] exp_rx[$];
    kev_t       exp_key[$];
    int exp_err = 0;
    int err_seen = 0;
    int rx_seen = 0;
    int stb_seen = 0;
    logic prev_valid = 1'b0;

    logic       m_ext = 1'b0;
    logic       m_rel = 1'b0;
    logic [3:0] m_mods = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Model: a byte is either a prefix (sets a flag) or a key event.
    task automatic model_byte(input logic [7:0] b);
        kev_t e;
        exp_rx.push_back(b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            if (b == 8'h12) m_mods[0] = !m_rel;
            if (b == 8'h59) m_mods[1] = !m_rel;
            if (b == 8'h14) m_mods[2] = !m_rel;
            if (b == 8'h11) m_mods[3] = !m_rel;
            e.code = b;
            e.ext  = m_ext;
            e.rel  = m_rel;
            e.mods = m_mods;
            exp_key.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        kev_t e;
        if (rx_valid) begin
            rx_seen++;
            if (exp_rx.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hFFFF);
            else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
        end
        if (key_strobe) begin
            stb_seen++;
            chk("strobe_latency", {31'h0, prev_valid}, 32'd1);
            if (exp_key.size() == 0) chk("key_unexpected", {24'h0, key_code}, 32'hFFFF);
            else begin
                e = exp_key.pop_front();
                chk("key_code", {24'h0, key_code}, {24'h0, e.code});
                chk("key_ext", {31'h0, key_ext}, {31'h0, e.ext});
                chk("key_rel", {31'h0, key_released}, {31'h0, e.rel});
                chk("key_mods", {28'h0, key_mods}, {28'h0, e.mods});
            end
        end
        if (rx_err) begin
            err_seen++;
            chk("err_expected", {31'h0, (exp_err > 0)}, 32'd1);
            if (exp_err > 0) exp_err--;
        end
        prev_valid = rx_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Sends the first nbits of a frame; 202-cycle bit period.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(50);
            ps2_clk = 1'b0;
            cyc(101);
            ps2_clk = 1'b1;
            cyc(51);
        end
        ps2_data = 1'b1;
        cyc(150);
    endtask

    task automatic good(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic settle();
        cyc(20);
        chk("rx_queue_drained", exp_rx.size(), 32'd0);
        chk("key_queue_drained", exp_key.size(), 32'd0);
        chk("err_queue_drained", exp_err, 32'd0);
    endtask

    int e0, r0, s0;

    initial begin
        cyc(5);
        chk("reset_rx_valid", {31'h0, rx_valid}, 32'd0);
        chk("reset_key_code", {24'h0, key_code}, 32'd0);
        chk("reset_key_mods", {28'h0, key_mods}, 32'd0);
        reset = 1'b0;
        cyc(10);

        good(8'h1C);
        settle();
        chk("pin_1c_rx", {24'h0, rx_data}, 32'h1C);
        chk("pin_1c_code", {24'h0, key_code}, 32'h1C);
        chk("pin_1c_ext", {31'h0, key_ext}, 32'd0);
        chk("pin_1c_rel", {31'h0, key_released}, 32'd0);

        good(8'h12);
        settle();
        chk("pin_lshift_on", {28'h0, key_mods}, 32'h1);
        good(8'hF0);
        good(8'h12);
        settle();
        chk("pin_lshift_off", {28'h0, key_mods}, 32'h0);
        chk("pin_lshift_rel", {31'h0, key_released}, 32'd1);

        r0 = rx_seen;
        s0 = stb_seen;
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        settle();
        chk("pin_e0f0_rx_cnt", rx_seen - r0, 32'd3);
        chk("pin_e0f0_stb_cnt", stb_seen - s0, 32'd1);
        chk("pin_e0f0_code", {24'h0, key_code}, 32'h75);
        chk("pin_e0f0_ext", {31'h0, key_ext}, 32'd1);
        chk("pin_e0f0_rel", {31'h0, key_released}, 32'd1);

        good(8'hF0);
        good(8'hE0);
        good(8'h11);
        settle();
        chk("pin_f0e0_ext", {31'h0, key_ext}, 32'd1);
        chk("pin_f0e0_rel", {31'h0, key_released}, 32'd1);

        e0 = err_seen;
        r0 = rx_seen;
        model_err();
        send_frame(8'h33, 1'b0, 1'b0, 11);
        settle();
        chk("pin_stop_err_cnt", err_seen - e0, 32'd1);
        chk("pin_stop_no_rx", rx_seen - r0, 32'd0);
        good(8'h2A);
        settle();
        chk("pin_2a_code", {24'h0, key_code}, 32'h2A);

        e0 = err_seen;
        model_err();
        send_frame(8'h16, 1'b0, 1'b1, 5);
        cyc(2600);
        settle();
        chk("pin_timeout_err_cnt", err_seen - e0, 32'd1);
        good(8'h16);
        settle();
        chk("pin_16_code", {24'h0, key_code}, 32'h16);

        e0 = err_seen;
        r0 = rx_seen;
`ifdef PS2_RX_PARITY_CHECK_EN
        model_err();
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        settle();
        chk("pin_par_err_cnt", err_seen - e0, 32'd1);
        chk("pin_par_no_rx", rx_seen - r0, 32'd0);
`else
        model_byte(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        settle();
        chk("pin_par_rx_cnt", rx_seen - r0, 32'd1);
        chk("pin_par_rx_data", {24'h0, rx_data}, 32'h1C);
`endif

        good(8'h14);
        settle();
        chk("pin_ctrl_on", {28'h0, key_mods}, 32'h4);

        send_frame(8'h55, 1'b0, 1'b1, 4);
        reset = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        m_mods = 4'h0;
        cyc(3);
        chk("rst_rx_data", {24'h0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
        chk("rst_rx_err", {31'h0, rx_err}, 32'd0);
        chk("rst_key_code", {24'h0, key_code}, 32'd0);
        chk("rst_key_ext", {31'h0, key_ext}, 32'd0);
        chk("rst_key_rel", {31'h0, key_released}, 32'd0);
        chk("rst_key_strobe", {31'h0, key_strobe}, 32'd0);
        chk("rst_key_mods", {28'h0, key_mods}, 32'd0);
        reset = 1'b0;
        cyc(10);
        good(8'h05);
        settle();
        chk("pin_05_code", {24'h0, key_code}, 32'h05);
        chk("pin_05_ext", {31'h0, key_ext}, 32'd0);
        chk("pin_05_rel", {31'h0, key_released}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
